// File: rtl/gpio_pad_responder.sv
// Small first-word-fall-through FIFO used for the pad event log.
// Latency: a pushed word is visible at rd_dat one cycle after the push edge.
// Backpressure: push and pop together are accepted even when full; a push while full without a pop is dropped and flagged on drop.
module gpio_evt_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    input  logic                       rd_rdy,
    output logic                       rd_vld,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          pop_ok;
    logic          push_ok;

    assign rd_vld  = (count != '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = rd_vld & rd_rdy;
    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign push_ok = wr_vld & (~full | pop_ok);
    assign drop    = wr_vld & full & ~pop_ok;
    assign rd_dat  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only visible while count is non-zero.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wr_dat;
    end
endmodule

`ifndef GPIO_DATA_WIDTH
`define GPIO_DATA_WIDTH 16
`endif

// Pad ring model: resolves DUT/external/pull drive per pin, returns it delayed, logs transitions.
// Latency: pad_val one edge after inputs, gpio_pin_in PAD_DLY edges, event visible one edge after pad_val changes.
// Backpressure: evt_ready pops the event log; events arriving while it is full and not popping are dropped (evt_overflow).
module gpio_pad_responder #(
    parameter int DATA_W     = `GPIO_DATA_WIDTH,
    parameter int PAD_DLY    = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int TS_W       = 16
) (
    input  logic                            pclk,
    input  logic                            p_reset,
    input  logic [DATA_W-1:0]               n_gpio_pin_oe,
    input  logic [DATA_W-1:0]               gpio_pin_out,
    output logic [DATA_W-1:0]               gpio_pin_in,
    input  logic [DATA_W-1:0]               ext_drive_en,
    input  logic [DATA_W-1:0]               ext_drive_val,
    input  logic [DATA_W-1:0]               pull_val,
    output logic [DATA_W-1:0]               pad_val,
    output logic [DATA_W-1:0]               contention,
    input  logic                            status_clr,
    output logic                            evt_valid,
    input  logic                            evt_ready,
    output logic [TS_W+DATA_W-1:0]          evt_data,
    output logic                            evt_overflow,
    output logic [$clog2(FIFO_DEPTH):0]     evt_count
);
    logic [DATA_W-1:0] resolved;
    logic [DATA_W-1:0] pipe [PAD_DLY];
    logic [DATA_W-1:0] prev_pad;
    logic [TS_W-1:0]   ts;
    logic              evt_push;
    logic              fifo_drop;

    // DUT drive wins whenever its enable is active, even against an external driver.
    assign resolved = (~n_gpio_pin_oe & gpio_pin_out)
                    | (n_gpio_pin_oe & ext_drive_en & ext_drive_val)
                    | (n_gpio_pin_oe & ~ext_drive_en & pull_val);

    assign pad_val     = pipe[0];
    assign gpio_pin_in = pipe[PAD_DLY-1];
    assign evt_push    = (pad_val != prev_pad);

    // Pad register followed by the return-path delay line.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            for (int k = 0; k < PAD_DLY; k++) pipe[k] <= '0;
        end else begin
            pipe[0] <= resolved;
            for (int k = 1; k < PAD_DLY; k++) pipe[k] <= pipe[k-1];
        end
    end

    // Transition detector history and free-running timestamp.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            prev_pad <= '0;
            ts       <= '0;
        end else begin
            prev_pad <= pad_val;
            ts       <= ts + TS_W'(1);
        end
    end

    // Sticky status; a new set in the same cycle outranks the clear.
    always_ff @(posedge pclk or posedge p_reset) begin
        if (p_reset) begin
            contention   <= '0;
            evt_overflow <= 1'b0;
        end else begin
            contention   <= (contention & ~{DATA_W{status_clr}}) | (~n_gpio_pin_oe & ext_drive_en);
            evt_overflow <= (evt_overflow & ~status_clr) | fifo_drop;
        end
    end

    gpio_evt_fifo #(
        .W     (TS_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk    (pclk),
        .rst    (p_reset),
        .wr_vld (evt_push),
        .wr_dat ({ts, pad_val}),
        .rd_rdy (evt_ready),
        .rd_vld (evt_valid),
        .rd_dat (evt_data),
        .count  (evt_count),
        .drop   (fifo_drop)
    );
endmodule
